serial_frame_deser: RTL

Serial-to-parallel frame receiver that sits directly downstream of the shift register stage's serial output. It consumes a framed bit stream: idle 0s, a start bit of 1, then DATA_WIDTH data bits MSB-first. Each assembled word goes into a small first-word-fall-through output FIFO with a valid/ready handshake. Back-pressure propagates upstream via in_ready.

---
 rtl/serial_frame_deser_if.sv | 22 ++
 rtl/serial_frame_deser.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deser_if.sv
// Handshake bundle for serial_frame_deser: serial bit input stream and parallel word output stream.
interface serial_frame_deser_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  in_valid;
  logic                  in_bit;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  par_err;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_data, par_err
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_data, par_err
  );
endinterface

// File: rtl/serial_frame_deser.sv
// Framed serial receiver (start bit + DATA_WIDTH bits MSB-first) feeding a first-word-fall-through FIFO.
// Optional even-parity bit after the data is enabled by defining SERIAL_FRAME_DESER_PARITY_EN.
module serial_frame_deser #(
  parameter int DATA_WIDTH = 4,
  parameter int FIFO_DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  serial_frame_deser_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
`ifdef SERIAL_FRAME_DESER_PARITY_EN
    S_PARITY = 2'd2,
`endif
    S_DATA   = 2'd1
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_err_q, par_err_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]         count_q, count_d;

  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;
  logic [DATA_WIDTH-1:0] push_word_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? PW'(0) : p + PW'(1);
  endfunction

`ifdef SERIAL_FRAME_DESER_PARITY_EN
  function automatic logic even_parity_ok(input logic [DATA_WIDTH-1:0] w, input logic p);
    return ((^w) ^ p) == 1'b0;
  endfunction
`endif

  // Readiness depends only on registered occupancy, so a stalled frame simply waits in place.
  assign bus.in_ready  = (count_q != NW'(FIFO_DEPTH));
  assign bus.out_valid = (count_q != NW'(0));
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.par_err   = par_err_q;

  assign accept_s = bus.in_valid && bus.in_ready;
  assign pop_s    = (count_q != NW'(0)) && bus.out_ready;

  // Frame FSM next-state: start detection, MSB-first shifting and word push.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    par_err_d   = 1'b0;
    push_s      = 1'b0;
    push_word_s = shreg_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && bus.in_bit) begin
          state_d = S_DATA;
          cnt_d   = CW'(0);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          shreg_d = {shreg_q[DATA_WIDTH-2:0], bus.in_bit};
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d = CW'(0);
`ifdef SERIAL_FRAME_DESER_PARITY_EN
            state_d = S_PARITY;
`else
            push_s      = 1'b1;
            push_word_s = {shreg_q[DATA_WIDTH-2:0], bus.in_bit};
            state_d     = S_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef SERIAL_FRAME_DESER_PARITY_EN
      S_PARITY: begin
        if (accept_s) begin
          state_d = S_IDLE;
          if (even_parity_ok(shreg_q, bus.in_bit)) begin
            push_s = 1'b1;
          end else begin
            par_err_d = 1'b1;
          end
        end else begin
          state_d = S_PARITY;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = CW'(0);
      end
    endcase
  end

  // FIFO next-state; a push never meets a full FIFO because in_ready gates the final bit.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = push_word_s;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers for FSM, shifter and FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= CW'(0);
      shreg_q   <= '0;
      par_err_q <= 1'b0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= PW'(0);
      rd_ptr_q  <= PW'(0);
      count_q   <= NW'(0);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      par_err_q <= par_err_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end
endmodule
